// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Input conditioner for the raw board switch bus. Each bit is brought into
// the clk domain with a two-flop synchronizer, then sampled on a shared
// divided tick. A bit's new level is accepted only after STABLE_N
// consecutive equal tick samples. Accepted changes are latched into a
// sticky mask that the switch peripheral clears with a one-cycle ack.
//
// Parameters:
//   WIDTH     number of switch bits
//   TICK_DIV  clk cycles per sample tick (>= 1, 1 = tick every cycle)
//   STABLE_N  consecutive equal samples needed to accept a level (>= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-low reset
//   sw_raw      raw, asynchronous, bouncing switch levels
//   ack         one-cycle pulse on status read, clears sw_changed
//   sw_stable   debounced switch word (registered)
//   sw_changed  sticky per-bit change mask since last ack (registered)
//   chg_int     OR of sw_changed, one cycle behind it (registered)
// ---------------------------------------------------------------------------
module switch_debounce #(
    parameter int WIDTH    = 32,
    parameter int TICK_DIV = 50000,
    parameter int STABLE_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             ack,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_changed,
    output logic             chg_int
);

    // Number of stored history samples; the current synchronized sample
    // completes the STABLE_N-wide acceptance window.
    localparam int HIST_N = STABLE_N - 1;
    // A one-bit counter is kept even for TICK_DIV=1 so no zero-width vector
    // is ever declared; it simply stays at zero.
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] hist_q [HIST_N];
    logic [WIDTH-1:0] hist_d [HIST_N];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_s;
    logic [WIDTH-1:0] all_one_s;
    logic [WIDTH-1:0] all_zero_s;
    logic [WIDTH-1:0] accept_s;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] changed_q;
    logic [WIDTH-1:0] changed_d;
    logic             chg_int_q;
    logic             chg_int_d;

    // Sample tick divider: counts 0..TICK_DIV-1, tick on the last count.
    always_comb begin
        tick_s = 1'b0;
        cnt_d  = cnt_q;
        if (cnt_q == CNT_MAX) begin
            tick_s = 1'b1;
            cnt_d  = CNT_ZERO;
        end else begin
            tick_s = 1'b0;
            cnt_d  = cnt_q + CNT_ONE;
        end
    end

    // Window reduction: a bit qualifies when history and current sample all agree.
    always_comb begin
        all_one_s  = sync2_q;
        all_zero_s = ~sync2_q;
        for (int k = 0; k < HIST_N; k++) begin
            all_one_s  = all_one_s & hist_q[k];
            all_zero_s = all_zero_s & ~hist_q[k];
        end
    end

    // Acceptance: on a tick, flag bits whose agreed level differs from sw_stable.
    always_comb begin
        accept_s = W_ZERO;
        if (tick_s) begin
            accept_s = (all_one_s & ~stable_q) | (all_zero_s & stable_q);
        end else begin
            accept_s = W_ZERO;
        end
    end

    // History shift register: newest sample enters at index 0 on each tick.
    always_comb begin
        for (int k = 0; k < HIST_N; k++) begin
            hist_d[k] = hist_q[k];
        end
        if (tick_s) begin
            for (int k = HIST_N - 1; k > 0; k--) begin
                hist_d[k] = hist_q[k-1];
            end
            hist_d[0] = sync2_q;
        end else begin
            for (int k = 0; k < HIST_N; k++) begin
                hist_d[k] = hist_q[k];
            end
        end
    end

    // Output next-state: accepted bits flip sw_stable; set beats ack-clear in the mask.
    always_comb begin
        stable_d  = stable_q ^ accept_s;
        changed_d = changed_q | accept_s;
        if (ack) begin
            changed_d = accept_s;
        end else begin
            changed_d = changed_q | accept_s;
        end
        chg_int_d = |changed_q;
    end

    // State registers, all cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= W_ZERO;
            sync2_q   <= W_ZERO;
            for (int k = 0; k < HIST_N; k++) begin
                hist_q[k] <= W_ZERO;
            end
            cnt_q     <= CNT_ZERO;
            stable_q  <= W_ZERO;
            changed_q <= W_ZERO;
            chg_int_q <= 1'b0;
        end else begin
            sync1_q   <= sw_raw;
            sync2_q   <= sync1_q;
            for (int k = 0; k < HIST_N; k++) begin
                hist_q[k] <= hist_d[k];
            end
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            changed_q <= changed_d;
            chg_int_q <= chg_int_d;
        end
    end

    assign sw_stable  = stable_q;
    assign sw_changed = changed_q;
    assign chg_int    = chg_int_q;

endmodule

// File: tb/tb_switch_debounce.sv
// ---------------------------------------------------------------------------
// tb_switch_debounce
//
// Directed bench for switch_debounce with TICK_DIV=4, STABLE_N=3.
// edge_n counts rising clk edges since the last reset release, so ticks
// land on edges 4, 8, 12, ... A raw change driven just after edge E is
// first seen by the tick at or after edge E+3 (two synchronizer stages).
// ---------------------------------------------------------------------------
module tb_switch_debounce;

    localparam int WIDTH    = 32;
    localparam int TICK_DIV = 4;
    localparam int STABLE_N = 3;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] sw_raw;
    logic             ack;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_changed;
    logic             chg_int;

    int checks;
    int errors;
    int edge_n;

    switch_debounce #(
        .WIDTH   (WIDTH),
        .TICK_DIV(TICK_DIV),
        .STABLE_N(STABLE_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .ack       (ack),
        .sw_stable (sw_stable),
        .sw_changed(sw_changed),
        .chg_int   (chg_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n = edge_n + 1;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) begin
            step();
        end
    endtask

    // Hold reset for a few cycles with the given raw level, release at a negedge.
    task automatic do_reset(input logic [WIDTH-1:0] raw);
        @(negedge clk);
        rst    = 1'b0;
        ack    = 1'b0;
        sw_raw = raw;
        repeat (3) @(negedge clk);
        rst    = 1'b1;
        edge_n = 0;
    endtask

    task automatic test_reset();
        do_reset(32'hFFFF_FFFF);
        run_to(16);
        checks++;
        if (sw_stable !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL reset_pre_stable got=%h exp=%h", sw_stable, 32'hFFFF_FFFF);
        end
        // Asynchronous assertion between edges, no clk edge in between.
        rst = 1'b0;
        #1;
        checks++;
        if (sw_stable !== 32'h0 || sw_changed !== 32'h0 || chg_int !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got=%h/%h/%b exp=0/0/0", sw_stable, sw_changed, chg_int);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sw_stable !== 32'h0 || sw_changed !== 32'h0 || chg_int !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got=%h/%h/%b exp=0/0/0", sw_stable, sw_changed, chg_int);
        end
    endtask

    task automatic test_clean_step();
        do_reset(32'h0000_0001);
        run_to(11);
        checks++;
        if (sw_stable !== 32'h0 || sw_changed !== 32'h0) begin
            errors++;
            $display("FAIL step_early got=%h/%h exp=0/0", sw_stable, sw_changed);
        end
        run_to(12);
        checks++;
        if (sw_stable !== 32'h1 || sw_changed !== 32'h1 || chg_int !== 1'b0) begin
            errors++;
            $display("FAIL step_accept got=%h/%h/%b exp=1/1/0", sw_stable, sw_changed, chg_int);
        end
        run_to(13);
        checks++;
        if (chg_int !== 1'b1) begin
            errors++;
            $display("FAIL step_int got=%b exp=1", chg_int);
        end
    endtask

    task automatic test_bounce();
        // bit5 sampled high at ticks 20,24, low at 28, high at 32, low after.
        run_to(16);
        sw_raw = 32'h0000_0021;
        run_to(24);
        sw_raw = 32'h0000_0001;
        run_to(28);
        sw_raw = 32'h0000_0021;
        run_to(32);
        sw_raw = 32'h0000_0001;
        run_to(44);
        checks++;
        if (sw_stable !== 32'h1) begin
            errors++;
            $display("FAIL bounce_stable got=%h exp=%h", sw_stable, 32'h1);
        end
        checks++;
        if (sw_changed !== 32'h1) begin
            errors++;
            $display("FAIL bounce_changed got=%h exp=%h", sw_changed, 32'h1);
        end
    endtask

    task automatic test_ack();
        ack = 1'b1;
        run_to(45);
        ack = 1'b0;
        checks++;
        if (sw_changed !== 32'h0 || chg_int !== 1'b1) begin
            errors++;
            $display("FAIL ack_mask got=%h/%b exp=0/1", sw_changed, chg_int);
        end
        run_to(46);
        checks++;
        if (chg_int !== 1'b0 || sw_stable !== 32'h1) begin
            errors++;
            $display("FAIL ack_int got=%b/%h exp=0/1", chg_int, sw_stable);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(32'h0000_0001);
        run_to(13);
        checks++;
        if (sw_changed !== 32'h1 || chg_int !== 1'b1) begin
            errors++;
            $display("FAIL simul_prior got=%h/%b exp=1/1", sw_changed, chg_int);
        end
        // bit7 sampled at ticks 16,20,24 -> accepted on edge 24, same as ack.
        sw_raw = 32'h0000_0081;
        run_to(23);
        checks++;
        if (sw_stable !== 32'h1) begin
            errors++;
            $display("FAIL simul_early got=%h exp=%h", sw_stable, 32'h1);
        end
        ack = 1'b1;
        run_to(24);
        ack = 1'b0;
        checks++;
        if (sw_changed !== 32'h0000_0080 || sw_stable !== 32'h0000_0081 || chg_int !== 1'b1) begin
            errors++;
            $display("FAIL simul_edge got=%h/%h/%b exp=80/81/1", sw_changed, sw_stable, chg_int);
        end
        run_to(25);
        checks++;
        if (chg_int !== 1'b1 || sw_changed !== 32'h0000_0080) begin
            errors++;
            $display("FAIL simul_int got=%b/%h exp=1/80", chg_int, sw_changed);
        end
    endtask

    task automatic test_multi_wrap();
        do_reset(32'h0000_0001);
        run_to(13);
        ack = 1'b1;
        run_to(14);
        ack = 1'b0;
        checks++;
        if (sw_changed !== 32'h0) begin
            errors++;
            $display("FAIL multi_ack got=%h exp=0", sw_changed);
        end
        // Sampled at ticks 20,24,28 -> accepted on edge 28.
        sw_raw = 32'hA500_0000;
        run_to(27);
        checks++;
        if (sw_stable !== 32'h1) begin
            errors++;
            $display("FAIL multi_early got=%h exp=%h", sw_stable, 32'h1);
        end
        run_to(28);
        checks++;
        if (sw_stable !== 32'hA500_0000 || sw_changed !== 32'hA500_0001) begin
            errors++;
            $display("FAIL multi_accept got=%h/%h exp=a5000000/a5000001", sw_stable, sw_changed);
        end
        // 100 ticks later the phase must still be edges multiple of 4.
        run_to(429);
        sw_raw = 32'hA500_0002;
        run_to(439);
        checks++;
        if (sw_stable !== 32'hA500_0000) begin
            errors++;
            $display("FAIL wrap_early got=%h exp=a5000000", sw_stable);
        end
        run_to(440);
        checks++;
        if (sw_stable !== 32'hA500_0002 || sw_changed !== 32'hA500_0003) begin
            errors++;
            $display("FAIL wrap_accept got=%h/%h exp=a5000002/a5000003", sw_stable, sw_changed);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        rst    = 1'b0;
        ack    = 1'b0;
        sw_raw = 32'h0;
        test_reset();
        test_clean_step();
        test_bounce();
        test_ack();
        test_simultaneous();
        test_multi_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
